reg_writeback: RTL and testbench

Write-back stage for the MMIX core that collects register results from two producers and drives the `regwrite` port of `regfile`. It buffers results in a small in-order FIFO, arbitrates the two sources round-robin and issues at most one register write per cycle. A pending-write query port lets issue logic see whether a register still has an outstanding write.

---
 rtl/reg_writeback_pkg.sv | 39 +++
 rtl/regwb_fifo.sv | 78 +++++++
 rtl/reg_writeback.sv | 128 ++++++++++++
 tb/tb_reg_writeback.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_writeback_pkg.sv
// mmix_defs: shared types for the MMIX register write-back path.
// Holds the producer request format, the regfile write port format,
// target-file encodings and the round-robin pointer type.
package mmix_defs;

  // Result produced by an execution unit, targeted at one or both files.
  typedef struct packed {
    logic [1:0]  file;
    logic [7:0]  addr;
    logic [63:0] data;
  } wb_req;

  // Write port of regfile: enable is one bit per file (bit0 global, bit1 local).
  typedef struct packed {
    logic [1:0]  enable;
    logic [7:0]  addr;
    logic [63:0] data;
  } regwrite;

  localparam logic [1:0] WB_FILE_NONE = 2'b00;
  localparam logic [1:0] WB_FILE_G    = 2'b01;
  localparam logic [1:0] WB_FILE_L    = 2'b10;

  // Which source wins when both are valid.
  typedef enum logic {
    RR_S0 = 1'b0,
    RR_S1 = 1'b1
  } rr_e;

  // A write targets the queried register if the numbers agree and the
  // file sets overlap.
  function automatic logic wb_match(input logic [1:0] w_file,
                                    input logic [7:0] w_addr,
                                    input logic [1:0] q_file,
                                    input logic [7:0] q_addr);
    return ((w_file & q_file) != 2'b00) && (w_addr == q_addr);
  endfunction

endpackage

// File: rtl/regwb_fifo.sv
// regwb_fifo: in-order DEPTH-entry buffer of wb_req for the write-back stage.
// Exposes occupancy and per-entry valid/file/addr so the parent can match
// pending-write queries against every queued entry.
module regwb_fifo
  import mmix_defs::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            push_i,
  input  wb_req           push_data_i,
  input  logic            pop_i,
  output wb_req           head_o,
  output logic [CW-1:0]   count_o,
  output logic [DEPTH-1:0] ent_valid_o,
  output logic [1:0]      ent_file_o [DEPTH],
  output logic [7:0]      ent_addr_o [DEPTH]
);

  wb_req         mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // Qualify push/pop against occupancy and compute next pointers/count.
  always_comb begin
    do_push  = push_i && (count_q != CW'(DEPTH));
    do_pop   = pop_i && (count_q != '0);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset flushes the buffer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are qualified by the valid mask, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Head and per-entry visibility: an entry is live if its distance from
  // the read pointer is below the occupancy.
  always_comb begin
    logic [AW-1:0] off;
    off     = '0;
    head_o  = mem_q[rd_ptr_q];
    count_o = count_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off            = AW'(i) - rd_ptr_q;
      ent_valid_o[i] = {1'b0, off} < count_q;
      ent_file_o[i]  = mem_q[i].file;
      ent_addr_o[i]  = mem_q[i].addr;
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: collects results from two producers (s0 = ALU, s1 = load
// unit), arbitrates round-robin, buffers them in order and drives one
// registered regwrite beat per cycle. q_hit flags outstanding writes.
// Optional feature: define REGWB_BYPASS_EN to load an accepted entry
// straight into regw when the buffer is empty and wb_hold is low.
module reg_writeback
  import mmix_defs::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   s0_valid,
  output logic                   s0_ready,
  input  logic [1:0]             s0_file,
  input  logic [7:0]             s0_addr,
  input  logic [63:0]            s0_data,
  input  logic                   s1_valid,
  output logic                   s1_ready,
  input  logic [1:0]             s1_file,
  input  logic [7:0]             s1_addr,
  input  logic [63:0]            s1_data,
  input  logic                   wb_hold,
  output regwrite                regw,
  input  logic [1:0]             q_file,
  input  logic [7:0]             q_addr,
  output logic                   q_hit,
  output logic [$clog2(DEPTH):0] pending
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]    count;
  wb_req            head;
  logic [DEPTH-1:0] ent_valid;
  logic [1:0]       ent_file [DEPTH];
  logic [7:0]       ent_addr [DEPTH];

  logic    full, acc0, acc1, keep, pop_ok, byp, push;
  wb_req   acc_req;
  rr_e     rr_q, rr_d;
  regwrite regw_q, regw_d;

  regwb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push),
    .push_data_i (acc_req),
    .pop_i       (pop_ok),
    .head_o      (head),
    .count_o     (count),
    .ent_valid_o (ent_valid),
    .ent_file_o  (ent_file),
    .ent_addr_o  (ent_addr)
  );

  // Handshake, source select and routing of the accepted entry.
  always_comb begin
    full     = (count == CW'(DEPTH));
    s0_ready = !full && ((rr_q == RR_S0) || !s1_valid);
    s1_ready = !full && ((rr_q == RR_S1) || !s0_valid);
    acc0     = s0_valid && s0_ready;
    acc1     = s1_valid && s1_ready;
    acc_req.file = acc0 ? s0_file : s1_file;
    acc_req.addr = acc0 ? s0_addr : s1_addr;
    acc_req.data = acc0 ? s0_data : s1_data;
    // Entries with no target file complete the handshake but are dropped.
    keep     = (acc0 || acc1) && (acc_req.file != WB_FILE_NONE);
    pop_ok   = (count != '0) && !wb_hold;
`ifdef REGWB_BYPASS_EN
    byp      = keep && (count == '0) && !wb_hold;
`else
    byp      = 1'b0;
`endif
    push     = keep && !byp;
  end

  // Round-robin pointer moves to the loser whenever both sources contend.
  always_comb begin
    rr_d = rr_q;
    if (s0_valid && s1_valid && !full) begin
      rr_d = (rr_q == RR_S0) ? RR_S1 : RR_S0;
    end
  end

  // Next regwrite beat: buffer head, bypassed entry, or an idle beat
  // that keeps the previous addr/data.
  always_comb begin
    regw_d        = regw_q;
    regw_d.enable = '0;
    if (pop_ok) begin
      regw_d.enable = head.file;
      regw_d.addr   = head.addr;
      regw_d.data   = head.data;
    end else if (byp) begin
      regw_d.enable = acc_req.file;
      regw_d.addr   = acc_req.addr;
      regw_d.data   = acc_req.data;
    end
  end

  // Arbitration pointer and output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_q   <= RR_S0;
      regw_q <= '0;
    end else begin
      rr_q   <= rr_d;
      regw_q <= regw_d;
    end
  end

  // Pending-write query over all live entries plus the in-flight beat.
  always_comb begin
    q_hit = wb_match(regw_q.enable, regw_q.addr, q_file, q_addr);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && wb_match(ent_file[i], ent_addr[i], q_file, q_addr)) begin
        q_hit = 1'b1;
      end
    end
  end

  assign regw    = regw_q;
  assign pending = count;

endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed stimulus with a write-order scoreboard for
// reg_writeback (DEPTH = 4). Bypass-specific expectations are selected by
// REGWB_BYPASS_EN, matching the design build.
module tb_reg_writeback;
  import mmix_defs::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        s0_valid, s1_valid, wb_hold;
  logic        s0_ready, s1_ready, q_hit;
  logic [1:0]  s0_file, s1_file, q_file;
  logic [7:0]  s0_addr, s1_addr, q_addr;
  logic [63:0] s0_data, s1_data;
  regwrite     regw;
  logic [$clog2(DEPTH):0] pending;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  regwrite exp_q [$];
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  reg_writeback #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_file(s0_file),
    .s0_addr(s0_addr), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_file(s1_file),
    .s1_addr(s1_addr), .s1_data(s1_data),
    .wb_hold(wb_hold), .regw(regw),
    .q_file(q_file), .q_addr(q_addr), .q_hit(q_hit), .pending(pending)
  );

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic regwrite rw(input logic [1:0] f, input logic [7:0] a, input logic [63:0] d);
    regwrite r;
    r.enable = f;
    r.addr   = a;
    r.data   = d;
    return r;
  endfunction

  // Every non-idle regw beat must be the oldest outstanding expected write.
  always @(negedge clk) begin
    regwrite e;
    if (mon_en && regw.enable != 2'b00) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 80'(exp_q.size()), 80'd1);
      end else begin
        e = exp_q.pop_front();
        chk("write_order", 80'(regw), 80'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    s0_valid = 1'b0;
    s1_valid = 1'b0;
  endtask

  task automatic drive0(input logic [1:0] f, input logic [7:0] a, input logic [63:0] d);
    s0_valid = 1'b1; s0_file = f; s0_addr = a; s0_data = d;
  endtask

  task automatic drive1(input logic [1:0] f, input logic [7:0] a, input logic [63:0] d);
    s1_valid = 1'b1; s1_file = f; s1_addr = a; s1_data = d;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", 80'(exp_q.size()), 80'd0);
    tick();
  endtask

  initial begin
    reset_n = 1'b0;
    wb_hold = 1'b0;
    idle();
    s0_file = '0; s0_addr = '0; s0_data = '0;
    s1_file = '0; s1_addr = '0; s1_data = '0;
    q_file = 2'b11; q_addr = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_regw", 80'(regw), 80'd0);
    chk("rst_pending", 80'(pending), 80'd0);
    chk("rst_qhit", 80'(q_hit), 80'd0);
    reset_n = 1'b1;
    tick();
    mon_en = 1'b1;

    // Single global write and its latency
    drive0(WB_FILE_G, 8'h20, 64'h1234);
    settle();
    chk("t1_ready", 80'(s0_ready), 80'd1);
    exp_q.push_back(rw(WB_FILE_G, 8'h20, 64'h1234));
    tick();
    idle();
`ifdef REGWB_BYPASS_EN
    chk("t1_byp_regw", 80'(regw), 80'(rw(WB_FILE_G, 8'h20, 64'h1234)));
    chk("t1_byp_pending", 80'(pending), 80'd0);
    tick();
    chk("t1_en_off", 80'(regw.enable), 80'd0);
`else
    chk("t1_lat1_en", 80'(regw.enable), 80'd0);
    chk("t1_pending", 80'(pending), 80'd1);
    tick();
    chk("t1_lat2_regw", 80'(regw), 80'(rw(WB_FILE_G, 8'h20, 64'h1234)));
    tick();
    chk("t1_en_off", 80'(regw.enable), 80'd0);
`endif
    tick();

    // Entry with no target file: accepted then dropped
    drive0(WB_FILE_NONE, 8'h21, 64'hDEAD);
    settle();
    chk("drop_ready", 80'(s0_ready), 80'd1);
    tick();
    idle();
    chk("drop_pending", 80'(pending), 80'd0);
    repeat (3) tick();

    // Round-robin with both sources contending
    drive0(WB_FILE_G, 8'h30, 64'hA0);
    drive1(WB_FILE_L, 8'h40, 64'hB0);
    settle();
    chk("rr0_s0", 80'(s0_ready), 80'd1);
    chk("rr0_s1", 80'(s1_ready), 80'd0);
    exp_q.push_back(rw(WB_FILE_G, 8'h30, 64'hA0));
    tick();
    drive0(WB_FILE_G, 8'h31, 64'hA1);
    settle();
    chk("rr1_s0", 80'(s0_ready), 80'd0);
    chk("rr1_s1", 80'(s1_ready), 80'd1);
    exp_q.push_back(rw(WB_FILE_L, 8'h40, 64'hB0));
    tick();
    drive1(WB_FILE_L, 8'h41, 64'hB1);
    settle();
    chk("rr2_s0", 80'(s0_ready), 80'd1);
    chk("rr2_s1", 80'(s1_ready), 80'd0);
    exp_q.push_back(rw(WB_FILE_G, 8'h31, 64'hA1));
    tick();
    s0_valid = 1'b0;
    settle();
    chk("rr3_s1_alone", 80'(s1_ready), 80'd1);
    exp_q.push_back(rw(WB_FILE_L, 8'h41, 64'hB1));
    tick();
    idle();
    drain(20);

    // Sustained throughput: one write per cycle
    for (int i = 0; i < 6; i++) begin
      drive0(WB_FILE_G, 8'h70 + 8'(i), 64'h700 + 64'(i));
      settle();
      chk("tput_ready", 80'(s0_ready), 80'd1);
      exp_q.push_back(rw(WB_FILE_G, 8'h70 + 8'(i), 64'h700 + 64'(i)));
      tick();
`ifdef REGWB_BYPASS_EN
      chk("tput_pending", 80'(pending), 80'd0);
      chk("tput_en", 80'(regw.enable), 80'(WB_FILE_G));
`else
      chk("tput_pending", 80'(pending), 80'd1);
      if (i > 0) chk("tput_en", 80'(regw.enable), 80'(WB_FILE_G));
`endif
    end
    idle();
    drain(20);

    // Full buffer under wb_hold
    wb_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive0(WB_FILE_G, 8'h50 + 8'(i), 64'h500 + 64'(i));
      settle();
      chk("full_ready", 80'(s0_ready), 80'(i < 4));
      if (i < 4) begin
        exp_q.push_back(rw(WB_FILE_G, 8'h50 + 8'(i), 64'h500 + 64'(i)));
        tick();
      end
    end
    chk("full_pending", 80'(pending), 80'd4);
    chk("full_s1_ready", 80'(s1_ready), 80'd0);
    wb_hold = 1'b0;
    settle();
    chk("full_release_ready", 80'(s0_ready), 80'd0);
    tick();
    chk("full_after_pop_pending", 80'(pending), 80'd3);
    chk("full_ready_back", 80'(s0_ready), 80'd1);
    exp_q.push_back(rw(WB_FILE_G, 8'h54, 64'h504));
    tick();
    idle();
    drain(20);

    // Pending-write query
    wb_hold = 1'b1;
    drive1(WB_FILE_L, 8'h05, 64'h55);
    settle();
    chk("q_ready", 80'(s1_ready), 80'd1);
    exp_q.push_back(rw(WB_FILE_L, 8'h05, 64'h55));
    tick();
    idle();
    q_file = WB_FILE_L; q_addr = 8'h05;
    settle();
    chk("q_hit_local", 80'(q_hit), 80'd1);
    q_file = WB_FILE_G;
    settle();
    chk("q_miss_global", 80'(q_hit), 80'd0);
    q_file = WB_FILE_L; q_addr = 8'h06;
    settle();
    chk("q_miss_addr", 80'(q_hit), 80'd0);
    q_file = 2'b11; q_addr = 8'h05;
    settle();
    chk("q_hit_both", 80'(q_hit), 80'd1);
    q_file = WB_FILE_L;
    wb_hold = 1'b0;
    tick();
    chk("q_hit_inflight", 80'(q_hit), 80'd1);
    chk("q_pending0", 80'(pending), 80'd0);
    tick();
    chk("q_hit_gone", 80'(q_hit), 80'd0);
    tick();

    // Reset in the middle of operation with queued writes
    wb_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive0(WB_FILE_G, 8'h60 + 8'(i), 64'h600 + 64'(i));
      tick();
    end
    idle();
    chk("mid_pending3", 80'(pending), 80'd3);
    q_file = WB_FILE_G; q_addr = 8'h61;
    settle();
    chk("mid_qhit_pre", 80'(q_hit), 80'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_regw", 80'(regw), 80'd0);
    chk("mid_rst_pending", 80'(pending), 80'd0);
    chk("mid_rst_qhit", 80'(q_hit), 80'd0);
    wb_hold = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (6) tick();
    chk("mid_after_pending", 80'(pending), 80'd0);

`ifdef REGWB_BYPASS_EN
    // Bypass into regw from an empty buffer
    drive0(2'b11, 8'h7F, '1);
    settle();
    chk("byp_ready", 80'(s0_ready), 80'd1);
    exp_q.push_back(rw(2'b11, 8'h7F, '1));
    tick();
    idle();
    chk("byp_regw", 80'(regw), 80'(rw(2'b11, 8'h7F, '1)));
    chk("byp_pending", 80'(pending), 80'd0);
    tick();
    chk("byp_en_off", 80'(regw.enable), 80'd0);
`endif
    chk("sb_final_empty", 80'(exp_q.size()), 80'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
